// File: rtl/fifo_sync_if.sv
// fifo_sync_if: write/read handshake, status and control bundle for fifo_sync
interface fifo_sync_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFFER_SIZE = 4
);
  localparam int LW = $clog2(BUFFER_SIZE) + 1;
  logic                  flush;
  logic                  error_clear;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_full;
  logic                  data_in_almost_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ack;
  logic                  data_out_almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output flush, error_clear, data_in, data_in_valid, data_out_ack,
    input  data_in_full, data_in_almost_full, data_out, data_out_valid,
           data_out_almost_empty, level, overflow, underflow
  );
  modport slave (
    input  flush, error_clear, data_in, data_in_valid, data_out_ack,
    output data_in_full, data_in_almost_full, data_out, data_out_valid,
           data_out_almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FWFT FIFO with thresholds, occupancy, flush and sticky error flags
module fifo_sync #(
  parameter int DATA_WIDTH         = 32,
  parameter int BUFFER_SIZE        = 4,
  parameter int ALMOST_FULL_LEVEL  = BUFFER_SIZE - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input logic clk,
  input logic rst,
  fifo_sync_if.slave bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int LW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic full, valid, push, pop, ovf_set, udf_set;
  // Status decodes only from the registered level, so ack never reaches full combinationally
  assign full    = level_q == LW'(BUFFER_SIZE);
  assign valid   = level_q != '0;
  assign push    = bus.data_in_valid && !full && !bus.flush;
  assign pop     = valid && bus.data_out_ack && !bus.flush;
  assign ovf_set = bus.data_in_valid && full && !bus.flush;
  assign udf_set = bus.data_out_ack && !valid && !bus.flush;
  always_comb begin
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(pop);
    level_d  = bus.flush ? '0 : level_q + LW'(push) - LW'(pop);
    ovf_d    = ovf_set || (ovf_q && !bus.error_clear);
    udf_d    = udf_set || (udf_q && !bus.error_clear);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_in;
  end
  assign bus.data_in_full          = full;
  assign bus.data_in_almost_full   = level_q >= LW'(ALMOST_FULL_LEVEL);
  assign bus.data_out_valid        = valid;
  assign bus.data_out              = valid ? mem[rd_ptr_q] : '0;
  assign bus.data_out_almost_empty = level_q <= LW'(ALMOST_EMPTY_LEVEL);
  assign bus.level                 = level_q;
  assign bus.overflow              = ovf_q;
  assign bus.underflow             = udf_q;
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed scoreboard bench for fifo_sync (depth 4, width 32)
module tb_fifo_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic ovf_m = 1'b0;
  logic udf_m = 1'b0;
  fifo_sync_if #(.DATA_WIDTH(32), .BUFFER_SIZE(4)) bus();
  fifo_sync #(.DATA_WIDTH(32), .BUFFER_SIZE(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(bus.level), q.size());
    chk({tag, ".valid"}, 32'(bus.data_out_valid), 32'(q.size() != 0));
    chk({tag, ".data"}, bus.data_out, q.size() != 0 ? q[0] : 32'h0);
    chk({tag, ".full"}, 32'(bus.data_in_full), 32'(q.size() == 4));
    chk({tag, ".afull"}, 32'(bus.data_in_almost_full), 32'(q.size() >= 3));
    chk({tag, ".aempty"}, 32'(bus.data_out_almost_empty), 32'(q.size() <= 1));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_m));
    chk({tag, ".udf"}, 32'(bus.underflow), 32'(udf_m));
  endtask
  task automatic cyc(input string tag, input logic wv, input logic [31:0] wd, input logic ack,
                     input logic fl = 1'b0, input logic ec = 1'b0);
    int sz;
    logic os, us;
    check_all(tag);
    bus.data_in_valid = wv;
    bus.data_in = wd;
    bus.data_out_ack = ack;
    bus.flush = fl;
    bus.error_clear = ec;
    @(posedge clk);
    #1;
    sz = q.size();
    os = wv && sz == 4 && !fl;
    us = ack && sz == 0 && !fl;
    if (fl) q.delete();
    else begin
      if (ack && sz > 0) void'(q.pop_front());
      if (wv && sz < 4) q.push_back(wd);
    end
    ovf_m = os || (ovf_m && !ec);
    udf_m = us || (udf_m && !ec);
    bus.data_in_valid = 1'b0;
    bus.data_out_ack = 1'b0;
    bus.flush = 1'b0;
    bus.error_clear = 1'b0;
  endtask
  initial begin
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    bus.data_out_ack = 1'b0;
    bus.flush = 1'b0;
    bus.error_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    // fill then drain, FWFT order
    for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 32'(i), 1'b0);
    chk("fill.full", 32'(bus.data_in_full), 32'd1);
    chk("fill.level4", 32'(bus.level), 32'd4);
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 32'h0, 1'b1);
    check_all("empty");
    // overflow, with and without a same-cycle pop
    for (int i = 1; i <= 4; i++) cyc("fill2", 1'b1, 32'(i), 1'b0);
    cyc("ovf5", 1'b1, 32'd5, 1'b0);
    cyc("ovf6", 1'b1, 32'd6, 1'b1);
    chk("ovf.level3", 32'(bus.level), 32'd3);
    chk("ovf.head2", bus.data_out, 32'd2);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    cyc("ovfclr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ovfclr.flag", 32'(bus.overflow), 32'd0);
    cyc("refill", 1'b1, 32'd11, 1'b0);
    cyc("setwins", 1'b1, 32'd12, 1'b0, 1'b0, 1'b1);
    chk("setwins.flag", 32'(bus.overflow), 32'd1);
    cyc("ovfclr2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("drain2", 1'b0, 32'h0, 1'b1);
    // simultaneous push/pop at level 2
    cyc("p7", 1'b1, 32'd7, 1'b0);
    cyc("p8", 1'b1, 32'd8, 1'b0);
    cyc("p9ack", 1'b1, 32'd9, 1'b1);
    chk("pp.level2", 32'(bus.level), 32'd2);
    chk("pp.head8", bus.data_out, 32'd8);
    cyc("ack8", 1'b0, 32'h0, 1'b1);
    chk("pp.head9", bus.data_out, 32'd9);
    cyc("ack9", 1'b0, 32'h0, 1'b1);
    // pointer wrap-around
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) cyc("wrapw", 1'b1, 32'h100 + 32'(r * 4 + i), 1'b0);
      for (int i = 0; i < 4; i++) cyc("wrapr", 1'b0, 32'h0, 1'b1);
    end
    // thresholds, flush and underflow
    cyc("t1", 1'b1, 32'h21, 1'b0);
    chk("thr.aempty1", 32'(bus.data_out_almost_empty), 32'd1);
    cyc("t2", 1'b1, 32'h22, 1'b0);
    chk("thr.aempty2", 32'(bus.data_out_almost_empty), 32'd0);
    chk("thr.afull2", 32'(bus.data_in_almost_full), 32'd0);
    cyc("t3", 1'b1, 32'h23, 1'b0);
    chk("thr.afull3", 32'(bus.data_in_almost_full), 32'd1);
    cyc("flush", 1'b1, 32'hA, 1'b1, 1'b1);
    chk("flush.level", 32'(bus.level), 32'd0);
    chk("flush.valid", 32'(bus.data_out_valid), 32'd0);
    cyc("udf", 1'b0, 32'h0, 1'b1);
    chk("udf.flag", 32'(bus.underflow), 32'd1);
    cyc("postflush", 1'b1, 32'h33, 1'b0);
    chk("postflush.head", bus.data_out, 32'h33);
    cyc("udfclr", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check_all("udfclr");
    // asynchronous reset mid-stream
    cyc("m1", 1'b1, 32'h41, 1'b0);
    cyc("m2", 1'b1, 32'h42, 1'b0);
    cyc("m3", 1'b1, 32'h43, 1'b0);
    cyc("m4", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc("m5", 1'b1, 32'h44, 1'b0);
    chk("mid.level3", 32'(bus.level), 32'd3);
    rst = 1'b1;
    #2;
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    check_all("arst");
    rst = 1'b0;
    cyc("after", 1'b1, 32'h55, 1'b0);
    cyc("after2", 1'b0, 32'h0, 1'b1);
    check_all("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised first-word-fall-through FIFO for same-domain buffering between producer and consumer stages. It keeps the valid/full write handshake and valid/ack read handshake of the dual-clock fifo. It adds:
- configurable depth and width
- almost-full/almost-empty thresholds
- an occupancy count
- synchronous flush
- sticky overflow/underflow error flags

## Interface
- DATA_WIDTH, 32, word width in bits
- BUFFER_SIZE, 4, depth in words; power of two, ≥ 2
- ALMOST_FULL_LEVEL, BUFFER_SIZE-1, data_in_almost_full asserts when level ≥ this
- ALMOST_EMPTY_LEVEL, 1, data_out_almost_empty asserts when level ≤ this
- clock  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- data_in  in  DATA_WIDTH  write data
- data_in_valid  in  1  write request
- data_in_full  out  1  FIFO holds BUFFER_SIZE words
- data_in_almost_full  out  1  level ≥ ALMOST_FULL_LEVEL
- data_out  out  DATA_WIDTH  head word; 0 when data_out_valid low
- data_out_valid  out  1  FIFO non-empty, head presented
- data_out_ack  in  1  consumer pops head
- data_out_almost_empty  out  1  level ≤ ALMOST_EMPTY_LEVEL
- level  out  $clog2(BUFFER_SIZE)+1  current occupancy, 0..BUFFER_SIZE
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: ack while empty
- error_clear  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: BUFFER_SIZE × DATA_WIDTH register array, not reset.
- Pointers: write and read pointers are $clog2(BUFFER_SIZE) bits wide and wrap modulo BUFFER_SIZE with no special case.
- level register: all status outputs decode from the registered level only.
  - data_in_full = (level == BUFFER_SIZE)
  - data_out_valid = (level != 0)
- Push: data_in_valid && !data_in_full.
  - Writes mem[wr_ptr].
  - Increments wr_ptr.
- Pop: data_out_valid && data_out_ack.
  - Increments rd_ptr.
- Level update per cycle:
  - push only: +1
  - pop only: −1
  - both: unchanged
- Full-cycle rule: a write while data_in_full is high is rejected even if a pop occurs in the same cycle. There is no combinational path from data_out_ack to data_in_full.
- Overflow: data_in_valid && data_in_full drops the word; overflow sets.
- Underflow: data_out_ack && !data_out_valid changes no state; underflow sets.
- Error flags stay set until error_clear or rst. If set and clear happen in the same cycle, set wins.
- FWFT read path: data_out = mem[rd_ptr] when data_out_valid, else 0. This is a combinational read of the array.
- Flush: on the next edge, level, wr_ptr and rd_ptr go to 0.
  - A push or pop in the flush cycle is ignored.
  - overflow/underflow are not affected.
  - Flush has priority over push, pop and error detection in that cycle.

## Timing
- Reset values (asynchronous on rst rise, held while high):
  - level = 0, pointers = 0
  - data_out_valid = 0, data_out = 0
  - data_in_full = 0, data_in_almost_full = 0
  - data_out_almost_empty = 1 (0 ≤ ALMOST_EMPTY_LEVEL)
  - overflow = 0, underflow = 0
- Write-to-read latency: a word pushed at edge N into an empty FIFO gives data_out_valid = 1 and data_out = word after edge N, so it can be acked in cycle N+1.
- Pop latency: after the ack edge, data_out shows the next word, or 0 with valid low, before the following edge.
- data_in_full rises after the edge that makes level = BUFFER_SIZE. It falls after the first pop edge.
- Sticky flags assert after the offending edge.
- Reset during operation: contents are discarded immediately and all outputs return to reset values without waiting for a clock edge.

## Test plan
- Reset/idle: assert rst mid-stream with 3 words held → level=0, data_out_valid=0, data_out=0, data_out_almost_empty=1, flags 0, with no clock edge required.
- Fill/drain order: push 1,2,3,4 on consecutive cycles with ack low → data_in_full=1, level=4. Then ack 4 cycles → data_out reads 1,2,3,4, then valid=0, level=0.
- Overflow: with FIFO full, push 5 alone, then push 6 together with ack → both dropped, overflow=1, level=3, head=2. error_clear → overflow=0.
- Simultaneous push/pop at level 2 holding 7,8: push 9 + ack → level stays 2, data_out=8, then 9.
- Wrap-around: 10 full fill/drain cycles of incrementing data (pointers wrap 10×) → every word matches the scoreboard, no flags set.
- Flush/underflow:
  - Flush with 3 words while pushing 0xA → level=0, valid=0, 0xA not stored.
  - Then ack while empty → underflow=1.
  - Thresholds: data_in_almost_full asserts exactly at level 3, data_out_almost_empty deasserts at level 2.
